// File: rtl/chan_packetizer_pkg.sv
// Shared definitions for the channel packetizer and the host-side parser model:
// FSM encodings, header field widths and header word builders.
package chan_packetizer_pkg;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_HDR0    = 2'd1;
    localparam logic [1:0] S_HDR1    = 2'd2;
    localparam logic [1:0] S_PAYLOAD = 2'd3;

    localparam logic [3:0] SYNC_NIBBLE = 4'hA;

    localparam int BIN_W = 11;
    localparam int LEN_W = 16;
    localparam int SEQ_W = 16;
    localparam int FFT_W = 12;

    // H0 = {sync[31:28], 0[27], bin[26:16], length[15:0]}
    function automatic logic [31:0] make_h0(input logic [3:0] sync,
                                            input logic [BIN_W-1:0] bin,
                                            input logic [LEN_W-1:0] plen);
        return {sync, 1'b0, bin, plen};
    endfunction

    // H1 = {seq[31:16], 0[15:12], fft_size[11:0]}
    function automatic logic [31:0] make_h1(input logic [SEQ_W-1:0] seq,
                                            input logic [FFT_W-1:0] fft);
        return {seq, 4'h0, fft};
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-stream register slice (output register plus one skid entry).
// in_ready comes straight from a flop, so there is no combinational path from out_ready.
module axis_skid_buf #(
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             accept;

    assign in_ready  = ~skid_valid_q;
    assign accept    = in_valid & in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (!out_valid_q || out_ready) begin
            // skid entry is older than anything arriving now, so it drains first
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) out_data_d = in_data;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/chan_packetizer.sv
// Frames channelizer packets for the host: two header words, then payload pass-through,
// with per-packet length checking. Output is registered through axis_skid_buf.
//
//  state     | meaning
//  S_IDLE    | waiting for first beat; latches header fields and issues H0 if the buffer has room
//  S_HDR0    | H0 still to be issued (buffer was full when the packet arrived)
//  S_HDR1    | issuing H1
//  S_PAYLOAD | passing input beats through until tlast
module chan_packetizer
    import chan_packetizer_pkg::*;
#(
    parameter int         DATA_WIDTH = 32,
    parameter int         BIN_WIDTH  = 11,
    parameter logic [3:0] SYNC_WORD  = SYNC_NIBBLE
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [23:0]           s_axis_tuser,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    input  logic                  eob_tag,
    input  logic [15:0]           payload_length,
    input  logic [11:0]           fft_size,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_teob,
    input  logic                  m_axis_tready,
    output logic                  len_err,
    output logic [7:0]            len_err_cnt
);

    logic [1:0]            state_q, state_d;
    logic [BIN_WIDTH-1:0]  bin_q, bin_d;
    logic [15:0]           plen_q, plen_d;
    logic [11:0]           fft_q, fft_d;
    logic [15:0]           seq_q, seq_d;
    logic [15:0]           beat_cnt_q, beat_cnt_d;
    logic                  eob_seen_q, eob_seen_d;
    logic                  len_err_q, len_err_d;
    logic [7:0]            len_err_cnt_q, len_err_cnt_d;

    logic                  sk_in_valid, sk_in_ready;
    logic [DATA_WIDTH+1:0] sk_in_data, sk_out_data;
    logic [15:0]           plen_in;
    logic                  unused_tuser;

    assign unused_tuser = ^s_axis_tuser[23:BIN_WIDTH];
    assign plen_in      = (payload_length == 16'd0) ? 16'd1 : payload_length;

    always_comb begin
        state_d       = state_q;
        bin_d         = bin_q;
        plen_d        = plen_q;
        fft_d         = fft_q;
        seq_d         = seq_q;
        beat_cnt_d    = beat_cnt_q;
        eob_seen_d    = eob_seen_q;
        len_err_d     = len_err_q;
        len_err_cnt_d = len_err_cnt_q;
        sk_in_valid   = 1'b0;
        sk_in_data    = '0;
        s_axis_tready = 1'b0;
        case (state_q)
            S_IDLE: begin
                // H0 is built from the live inputs so it reaches the output one cycle after tvalid
                if (s_axis_tvalid) begin
                    bin_d       = s_axis_tuser[BIN_WIDTH-1:0];
                    plen_d      = plen_in;
                    fft_d       = fft_size;
                    sk_in_valid = 1'b1;
                    sk_in_data  = {2'b00, make_h0(SYNC_WORD, s_axis_tuser[BIN_WIDTH-1:0], plen_in)};
                    state_d     = sk_in_ready ? S_HDR1 : S_HDR0;
                end
            end
            S_HDR0: begin
                sk_in_valid = 1'b1;
                sk_in_data  = {2'b00, make_h0(SYNC_WORD, bin_q, plen_q)};
                if (sk_in_ready) state_d = S_HDR1;
            end
            S_HDR1: begin
                sk_in_valid = 1'b1;
                sk_in_data  = {2'b00, make_h1(seq_q, fft_q)};
                if (sk_in_ready) state_d = S_PAYLOAD;
            end
            default: begin
                s_axis_tready = sk_in_ready;
                sk_in_valid   = s_axis_tvalid;
                sk_in_data    = {s_axis_tlast & (eob_tag | eob_seen_q), s_axis_tlast, s_axis_tdata};
                if (s_axis_tvalid && sk_in_ready) begin
                    if (s_axis_tlast) begin
                        state_d    = S_IDLE;
                        seq_d      = seq_q + 16'd1;
                        eob_seen_d = 1'b0;
                        beat_cnt_d = 16'd0;
                        if (({1'b0, beat_cnt_q} + 17'd1) != {1'b0, plen_q}) begin
                            len_err_d = 1'b1;
                            if (len_err_cnt_q != 8'hFF) len_err_cnt_d = len_err_cnt_q + 8'd1;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 16'd1;
                        if (eob_tag) eob_seen_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= S_IDLE;
            bin_q         <= '0;
            plen_q        <= 16'd1;
            fft_q         <= '0;
            seq_q         <= '0;
            beat_cnt_q    <= '0;
            eob_seen_q    <= 1'b0;
            len_err_q     <= 1'b0;
            len_err_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            bin_q         <= bin_d;
            plen_q        <= plen_d;
            fft_q         <= fft_d;
            seq_q         <= seq_d;
            beat_cnt_q    <= beat_cnt_d;
            eob_seen_q    <= eob_seen_d;
            len_err_q     <= len_err_d;
            len_err_cnt_q <= len_err_cnt_d;
        end
    end

    axis_skid_buf #(.WIDTH(DATA_WIDTH + 2)) u_skid (
        .clk       (clk),
        .rst_n     (aresetn),
        .in_valid  (sk_in_valid),
        .in_data   (sk_in_data),
        .in_ready  (sk_in_ready),
        .out_valid (m_axis_tvalid),
        .out_data  (sk_out_data),
        .out_ready (m_axis_tready)
    );

    assign m_axis_tdata = sk_out_data[DATA_WIDTH-1:0];
    assign m_axis_tlast = sk_out_data[DATA_WIDTH];
    assign m_axis_teob  = sk_out_data[DATA_WIDTH+1];
    assign len_err      = len_err_q;
    assign len_err_cnt  = len_err_cnt_q;

endmodule

// File: tb/tb_chan_packetizer.sv
// Directed bench for chan_packetizer: output words are collected into a queue and
// compared against words built by the bench from the packet parameters it drives.
module tb_chan_packetizer;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        s_axis_tvalid;
    logic [31:0] s_axis_tdata;
    logic [23:0] s_axis_tuser;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic        eob_tag;
    logic [15:0] payload_length;
    logic [11:0] fft_size;
    logic        m_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_teob;
    logic        m_axis_tready;
    logic        len_err;
    logic [7:0]  len_err_cnt;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          tog_en = 1'b0;
    logic [33:0] outq[$];
    int          outc[$];
    logic [33:0] expq[$];

    chan_packetizer dut (
        .clk            (clk),
        .aresetn        (aresetn),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tuser   (s_axis_tuser),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tready  (s_axis_tready),
        .eob_tag        (eob_tag),
        .payload_length (payload_length),
        .fft_size       (fft_size),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_teob    (m_axis_teob),
        .m_axis_tready  (m_axis_tready),
        .len_err        (len_err),
        .len_err_cnt    (len_err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (aresetn && m_axis_tvalid && m_axis_tready) begin
            outq.push_back({m_axis_teob, m_axis_tlast, m_axis_tdata});
            outc.push_back(cyc);
        end
    end

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (tog_en) m_axis_tready = ~m_axis_tready;
            else        m_axis_tready = 1'b1;
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic [10:0] bin,
                             input logic last, input logic eob);
        int n;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tuser  = {13'h1555, bin};
        s_axis_tlast  = last;
        eob_tag       = eob;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_axis_tready && n < 100);
        if (!s_axis_tready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: tready=%b after %0d cycles, required 1", s_axis_tready, n);
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        eob_tag       = 1'b0;
    endtask

    task automatic send_packet(input logic [10:0] bin, input int nbeats,
                               input logic [31:0] base, input int eob_idx);
        for (int i = 0; i < nbeats; i++)
            send_beat(base + i, bin, i == nbeats - 1, i == eob_idx);
    endtask

    task automatic expect_packet(input logic [10:0] bin, input logic [15:0] plen,
                                 input logic [15:0] seq, input logic [11:0] fft,
                                 input int nbeats, input logic [31:0] base, input int eob_idx);
        logic [15:0] pl;
        logic        eob_any;
        pl      = (plen == 16'd0) ? 16'd1 : plen;
        eob_any = (eob_idx >= 0) && (eob_idx < nbeats);
        expq.push_back({2'b00, 4'hA, 1'b0, bin, pl});
        expq.push_back({2'b00, seq, 4'h0, fft});
        for (int i = 0; i < nbeats; i++)
            expq.push_back({(i == nbeats - 1) && eob_any, i == nbeats - 1, base + i});
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (outq.size() < expq.size() && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        aresetn        = 1'b0;
        s_axis_tvalid  = 1'b0;
        s_axis_tdata   = '0;
        s_axis_tuser   = '0;
        s_axis_tlast   = 1'b0;
        eob_tag        = 1'b0;
        payload_length = 16'd4;
        fft_size       = 12'd256;
        repeat (3) @(negedge clk);
        checks++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_teob, s_axis_tready} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got mv/ml/me/sr=%b required 0000",
                     {m_axis_tvalid, m_axis_tlast, m_axis_teob, s_axis_tready});
        end
        checks++;
        if (m_axis_tdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_tdata: got %h required 00000000", m_axis_tdata);
        end
        checks++;
        if ({len_err, len_err_cnt} !== 9'h000) begin
            errors++;
            $display("FAIL reset_lenerr: got %b/%0d required 0/0", len_err, len_err_cnt);
        end
        aresetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_nominal();
        outq.delete(); outc.delete(); expq.delete();
        payload_length = 16'd4;
        fft_size       = 12'd256;
        expect_packet(11'h05A, 16'd4, 16'd0, 12'd256, 4, 32'h1000_0000, -1);
        fork
            send_packet(11'h05A, 4, 32'h1000_0000, -1);
            begin
                @(negedge clk);
                checks++;
                if (m_axis_tvalid !== 1'b0) begin
                    errors++;
                    $display("FAIL nominal_lat0: tvalid=%b required 0", m_axis_tvalid);
                end
                @(negedge clk);
                checks++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hA05A0004) begin
                    errors++;
                    $display("FAIL nominal_lat1: tvalid=%b data=%h required 1/a05a0004",
                             m_axis_tvalid, m_axis_tdata);
                end
            end
        join
        wait_out();
        checks++;
        if (outq.size() != 6) begin
            errors++;
            $display("FAIL nominal_count: got %0d words required 6", outq.size());
        end
        for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
            checks++;
            if (outq[i] !== expq[i]) begin
                errors++;
                $display("FAIL nominal_word%0d: got %h required %h", i, outq[i], expq[i]);
            end
        end
        checks++;
        if (outq.size() > 1 && outq[1][31:0] !== 32'h00000100) begin
            errors++;
            $display("FAIL nominal_h1: got %h required 00000100", outq[1][31:0]);
        end
        checks++;
        if (len_err !== 1'b0) begin
            errors++;
            $display("FAIL nominal_lenerr: got %b required 0", len_err);
        end
    endtask

    task automatic test_reset_mid();
        outq.delete(); outc.delete(); expq.delete();
        payload_length = 16'd8;
        send_beat(32'h2000_0000, 11'h003, 1'b0, 1'b0);
        send_beat(32'h2000_0001, 11'h003, 1'b0, 1'b0);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h2000_0002;
        #2;
        checks++;
        if (m_axis_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: tvalid=%b required 1", m_axis_tvalid);
        end
        aresetn = 1'b0;
        #1;
        checks++;
        if ({m_axis_tvalid, s_axis_tready} !== 2'b00 || m_axis_tdata !== 32'h0) begin
            errors++;
            $display("FAIL midrst_now: mv/sr=%b data=%h required 00/00000000",
                     {m_axis_tvalid, s_axis_tready}, m_axis_tdata);
        end
        s_axis_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        aresetn = 1'b1;
        @(posedge clk);
        #1;
        outq.delete(); outc.delete();
    endtask

    task automatic test_backpressure();
        outq.delete(); outc.delete(); expq.delete();
        payload_length = 16'd8;
        fft_size       = 12'd512;
        tog_en         = 1'b1;
        for (int p = 0; p < 3; p++) begin
            expect_packet(11'(p + 1), 16'd8, 16'(p), 12'd512, 8, 32'h3000_0000 + p * 16, -1);
            send_packet(11'(p + 1), 8, 32'h3000_0000 + p * 16, -1);
        end
        wait_out();
        tog_en = 1'b0;
        checks++;
        if (outq.size() != 30) begin
            errors++;
            $display("FAIL bp_count: got %0d words required 30", outq.size());
        end
        for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
            checks++;
            if (outq[i] !== expq[i]) begin
                errors++;
                $display("FAIL bp_word%0d: got %h required %h", i, outq[i], expq[i]);
            end
        end
    endtask

    task automatic test_eob();
        outq.delete(); outc.delete(); expq.delete();
        payload_length = 16'd4;
        fft_size       = 12'd128;
        expect_packet(11'h010, 16'd4, 16'd3, 12'd128, 4, 32'h4000_0000, 1);
        send_packet(11'h010, 4, 32'h4000_0000, 1);
        expect_packet(11'h011, 16'd4, 16'd4, 12'd128, 4, 32'h4100_0000, -1);
        send_packet(11'h011, 4, 32'h4100_0000, -1);
        expect_packet(11'h012, 16'd4, 16'd5, 12'd128, 4, 32'h4200_0000, 3);
        send_packet(11'h012, 4, 32'h4200_0000, 3);
        wait_out();
        checks++;
        if (outq.size() != 18) begin
            errors++;
            $display("FAIL eob_count: got %0d words required 18", outq.size());
        end
        for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
            checks++;
            if (outq[i] !== expq[i]) begin
                errors++;
                $display("FAIL eob_word%0d: got %h required %h", i, outq[i], expq[i]);
            end
        end
    endtask

    task automatic test_seq_wrap();
        outq.delete(); outc.delete(); expq.delete();
        payload_length = 16'd0;
        fft_size       = 12'd64;
        force dut.seq_q = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.seq_q;
        for (int p = 0; p < 3; p++)
            expect_packet(11'h007, 16'd1, 16'hFFFE + 16'(p), 12'd64, 1, 32'h5000_0000 + p, -1);
        for (int p = 0; p < 3; p++)
            send_packet(11'h007, 1, 32'h5000_0000 + p, -1);
        wait_out();
        checks++;
        if (outq.size() != 9) begin
            errors++;
            $display("FAIL wrap_count: got %0d words required 9", outq.size());
        end
        for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
            checks++;
            if (outq[i] !== expq[i]) begin
                errors++;
                $display("FAIL wrap_word%0d: got %h required %h", i, outq[i], expq[i]);
            end
        end
        checks++;
        if (outc.size() == 9 && (outc[8] - outc[0]) != 8) begin
            errors++;
            $display("FAIL wrap_throughput: 9 words spanned %0d cycles required 8", outc[8] - outc[0]);
        end
        checks++;
        if (len_err !== 1'b0) begin
            errors++;
            $display("FAIL wrap_lenerr: got %b required 0", len_err);
        end
    endtask

    task automatic test_len_err();
        outq.delete(); outc.delete(); expq.delete();
        payload_length = 16'd8;
        fft_size       = 12'd256;
        expect_packet(11'h020, 16'd8, 16'd1, 12'd256, 5, 32'h6000_0000, -1);
        send_packet(11'h020, 5, 32'h6000_0000, -1);
        wait_out();
        checks++;
        if (outq.size() != 7) begin
            errors++;
            $display("FAIL lenerr_count: got %0d words required 7", outq.size());
        end
        for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
            checks++;
            if (outq[i] !== expq[i]) begin
                errors++;
                $display("FAIL lenerr_word%0d: got %h required %h", i, outq[i], expq[i]);
            end
        end
        checks++;
        if (len_err !== 1'b1 || len_err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL lenerr_first: got %b/%0d required 1/1", len_err, len_err_cnt);
        end
        payload_length = 16'd2;
        for (int p = 0; p < 253; p++) send_packet(11'h021, 1, 32'h6100_0000, -1);
        @(negedge clk);
        checks++;
        if (len_err_cnt !== 8'd254) begin
            errors++;
            $display("FAIL lenerr_254: got %0d required 254", len_err_cnt);
        end
        send_packet(11'h021, 1, 32'h6100_0000, -1);
        @(negedge clk);
        checks++;
        if (len_err_cnt !== 8'd255) begin
            errors++;
            $display("FAIL lenerr_255: got %0d required 255", len_err_cnt);
        end
        for (int p = 0; p < 46; p++) send_packet(11'h021, 1, 32'h6100_0000, -1);
        @(negedge clk);
        checks++;
        if (len_err !== 1'b1 || len_err_cnt !== 8'd255) begin
            errors++;
            $display("FAIL lenerr_sat: got %b/%0d required 1/255", len_err, len_err_cnt);
        end
        payload_length = 16'd1;
        send_packet(11'h022, 1, 32'h6200_0000, -1);
        @(negedge clk);
        checks++;
        if (len_err !== 1'b1) begin
            errors++;
            $display("FAIL lenerr_sticky: got %b required 1", len_err);
        end
        aresetn = 1'b0;
        #1;
        checks++;
        if (len_err !== 1'b0 || len_err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL lenerr_reset: got %b/%0d required 0/0", len_err, len_err_cnt);
        end
        @(negedge clk);
        aresetn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_reset_mid();
        test_backpressure();
        test_eob();
        test_seq_wrap();
        test_len_err();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
